// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline controller and its
// control-register file: control-op and exception encodings, execution
// modes, control-register addresses and STATUS bit positions.
// Optional feature macro used by the importing files: PCTRL_IRQ_EN.
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_NOP  = 2'd0,
        CTRL_WRCR = 2'd1,
        CTRL_EXRT = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        EXP_NONE     = 3'd0,
        EXP_EXT_INT  = 3'd1,
        EXP_UNDEF    = 3'd2,
        EXP_OVF      = 3'd3,
        EXP_MISALIGN = 3'd4,
        EXP_TRAP     = 3'd5,
        EXP_PRV_VIO  = 3'd6
    } exp_code_e;

    typedef enum logic {
        MODE_KERNEL = 1'b0,
        MODE_USER   = 1'b1
    } exe_mode_e;

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_EXP_CODE   = 5'd2;
    localparam logic [4:0] CREG_VECTOR     = 5'd3;
    localparam logic [4:0] CREG_EPC        = 5'd4;
    localparam logic [4:0] CREG_IRQ_MASK   = 5'd5;

    localparam int STATUS_MODE_BIT = 0;
    localparam int STATUS_IE_BIT   = 1;

    // STATUS value loaded on exception entry: kernel mode, interrupts off.
    function automatic logic [1:0] status_exc_entry();
        logic [1:0] s;
        s = 2'b00;
        s[STATUS_MODE_BIT] = MODE_KERNEL;
        s[STATUS_IE_BIT]   = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_creg_file.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_creg_file (module creg_file)
// Control-register storage for the pipeline controller: STATUS, PRE_STATUS,
// EXP_CODE, VECTOR, EPC and (with PCTRL_IRQ_EN) IRQ_MASK. Updates are driven
// by one-hot commit strobes from pipe_ctrl; the read port is combinational
// with a bypass of a WRCR committing in the same cycle.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   exc_commit_i            exception commits this cycle
//   exc_code_i              {delay_flag, code} to store in EXP_CODE
//   exc_epc_i               word PC to store in EPC
//   exrt_commit_i           EXRT commits this cycle (STATUS <= PRE_STATUS)
//   wr_en_i/addr/data       WRCR commits this cycle
//   rd_addr_i / rd_data_o   decoder read port
//   status_o, vector_o, epc_o, irq_mask_o  live register values
// ----------------------------------------------------------------------------
module creg_file
    import pipe_ctrl_pkg::*;
#(
    parameter int DE_ADD_WIDTH  = 30,
    parameter int DE_DAT_WIDTH  = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int ISA_EXP_BUS   = 3,
    parameter int IRQ_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exc_commit_i,
    input  logic [ISA_EXP_BUS:0]     exc_code_i,
    input  logic [DE_ADD_WIDTH-1:0]  exc_epc_i,
    input  logic                     exrt_commit_i,
    input  logic                     wr_en_i,
    input  logic [REG_ADD_WIDTH-1:0] wr_addr_i,
    input  logic [DE_DAT_WIDTH-1:0]  wr_data_i,
    input  logic [REG_ADD_WIDTH-1:0] rd_addr_i,
    output logic [DE_DAT_WIDTH-1:0]  rd_data_o,
    output logic [1:0]               status_o,
    output logic [DE_DAT_WIDTH-1:0]  vector_o,
    output logic [DE_ADD_WIDTH-1:0]  epc_o,
    output logic [IRQ_WIDTH-1:0]     irq_mask_o
);

    localparam logic [REG_ADD_WIDTH-1:0] A_STATUS   = REG_ADD_WIDTH'(CREG_STATUS);
    localparam logic [REG_ADD_WIDTH-1:0] A_PRE      = REG_ADD_WIDTH'(CREG_PRE_STATUS);
    localparam logic [REG_ADD_WIDTH-1:0] A_EXP      = REG_ADD_WIDTH'(CREG_EXP_CODE);
    localparam logic [REG_ADD_WIDTH-1:0] A_VECTOR   = REG_ADD_WIDTH'(CREG_VECTOR);
    localparam logic [REG_ADD_WIDTH-1:0] A_EPC      = REG_ADD_WIDTH'(CREG_EPC);
`ifdef PCTRL_IRQ_EN
    localparam logic [REG_ADD_WIDTH-1:0] A_IRQ_MASK = REG_ADD_WIDTH'(CREG_IRQ_MASK);
`endif

    logic [1:0]               status_q,     status_d;
    logic [1:0]               pre_status_q, pre_status_d;
    logic [ISA_EXP_BUS:0]     exp_code_q,   exp_code_d;
    logic [DE_DAT_WIDTH-1:0]  vector_q,     vector_d;
    logic [DE_ADD_WIDTH-1:0]  epc_q,        epc_d;
    logic [DE_DAT_WIDTH-1:0]  rd_reg_s;
`ifdef PCTRL_IRQ_EN
    logic [IRQ_WIDTH-1:0]     irq_mask_q,   irq_mask_d;
`endif

    // Addresses that hold real storage; everything else reads 0 and
    // ignores writes (and is therefore never bypassed).
    function automatic logic addr_is_impl(input logic [REG_ADD_WIDTH-1:0] a);
        logic r;
        case (a)
            A_STATUS, A_PRE, A_EXP, A_VECTOR, A_EPC: r = 1'b1;
`ifdef PCTRL_IRQ_EN
            A_IRQ_MASK:                              r = 1'b1;
`endif
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state for all control registers; strobes are mutually exclusive.
    always_comb begin
        status_d     = status_q;
        pre_status_d = pre_status_q;
        exp_code_d   = exp_code_q;
        vector_d     = vector_q;
        epc_d        = epc_q;
`ifdef PCTRL_IRQ_EN
        irq_mask_d   = irq_mask_q;
`endif
        if (exc_commit_i) begin
            pre_status_d = status_q;
            status_d     = status_exc_entry();
            exp_code_d   = exc_code_i;
            epc_d        = exc_epc_i;
        end else if (exrt_commit_i) begin
            status_d = pre_status_q;
        end else if (wr_en_i) begin
            case (wr_addr_i)
                A_STATUS:   status_d     = wr_data_i[1:0];
                A_PRE:      pre_status_d = wr_data_i[1:0];
                A_EXP:      exp_code_d   = wr_data_i[ISA_EXP_BUS:0];
                A_VECTOR:   vector_d     = wr_data_i;
                A_EPC:      epc_d        = wr_data_i[DE_DAT_WIDTH-1:2];
`ifdef PCTRL_IRQ_EN
                A_IRQ_MASK: irq_mask_d   = wr_data_i[IRQ_WIDTH-1:0];
`endif
                default:    status_d     = status_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // Register storage; reset leaves the core in kernel mode, interrupts off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q     <= 2'b00;
            pre_status_q <= 2'b00;
            exp_code_q   <= {(ISA_EXP_BUS+1){1'b0}};
            vector_q     <= {DE_DAT_WIDTH{1'b0}};
            epc_q        <= {DE_ADD_WIDTH{1'b0}};
`ifdef PCTRL_IRQ_EN
            irq_mask_q   <= {IRQ_WIDTH{1'b0}};
`endif
        end else begin
            status_q     <= status_d;
            pre_status_q <= pre_status_d;
            exp_code_q   <= exp_code_d;
            vector_q     <= vector_d;
            epc_q        <= epc_d;
`ifdef PCTRL_IRQ_EN
            irq_mask_q   <= irq_mask_d;
`endif
        end
    end

    // Decoder read mux with same-cycle WRCR bypass.
    always_comb begin
        rd_reg_s = {DE_DAT_WIDTH{1'b0}};
        case (rd_addr_i)
            A_STATUS:   rd_reg_s = DE_DAT_WIDTH'(status_q);
            A_PRE:      rd_reg_s = DE_DAT_WIDTH'(pre_status_q);
            A_EXP:      rd_reg_s = DE_DAT_WIDTH'(exp_code_q);
            A_VECTOR:   rd_reg_s = vector_q;
            A_EPC:      rd_reg_s = {epc_q, 2'b00};
`ifdef PCTRL_IRQ_EN
            A_IRQ_MASK: rd_reg_s = DE_DAT_WIDTH'(irq_mask_q);
`endif
            default:    rd_reg_s = {DE_DAT_WIDTH{1'b0}};
        endcase
        if (wr_en_i && (wr_addr_i == rd_addr_i) && addr_is_impl(rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = rd_reg_s;
        end
    end

    assign status_o = status_q;
    assign vector_o = vector_q;
    assign epc_o    = epc_q;
`ifdef PCTRL_IRQ_EN
    assign irq_mask_o = irq_mask_q;
`else
    assign irq_mask_o = {IRQ_WIDTH{1'b0}};
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Central controller of the 5-stage pipeline. Produces per-stage stall and
// flush, the PC redirect, and commits exceptions / EXRT / WRCR at the MEM
// boundary so they are precise. Control registers live in creg_file.
// Optional feature: define PCTRL_IRQ_EN to enable IRQ_MASK and external
// interrupts on irq_i (2-flop synchronised, taken on a commit-free cycle).
// Ports:
//   if_busy_i, mem_busy_i, ld_hazard_i   stall sources
//   id_br_flag_i                         branch in ID (delay-slot tracking)
//   mem_en_i, mem_pc_i, mem_ctrl_op_i, mem_exp_code_i,
//   mem_dst_addr_i, mem_wr_data_i        MEM-stage instruction
//   creg_rd_addr_i / creg_rd_data_o      decoder control-register read
//   exe_mode_o                           0=kernel, 1=user
//   irq_i                                level interrupts (optional)
//   *_stall_o, *_flush_o                 per-stage hold / invalidate
//   new_pc_o, redirect_o                 PC redirect
// Stall, flush and redirect outputs are combinational by design.
// ----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DE_ADD_WIDTH  = 30,
    parameter int DE_DAT_WIDTH  = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int CTRL_OP_BUS   = 2,
    parameter int ISA_EXP_BUS   = 3,
    parameter int CPU_EXE_MODE  = 1,
    parameter int IRQ_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_busy_i,
    input  logic                     mem_busy_i,
    input  logic                     ld_hazard_i,
    input  logic                     id_br_flag_i,
    input  logic                     mem_en_i,
    input  logic [DE_ADD_WIDTH-1:0]  mem_pc_i,
    input  logic [CTRL_OP_BUS-1:0]   mem_ctrl_op_i,
    input  logic [ISA_EXP_BUS-1:0]   mem_exp_code_i,
    input  logic [REG_ADD_WIDTH-1:0] mem_dst_addr_i,
    input  logic [DE_DAT_WIDTH-1:0]  mem_wr_data_i,
    input  logic [REG_ADD_WIDTH-1:0] creg_rd_addr_i,
    output logic [DE_DAT_WIDTH-1:0]  creg_rd_data_o,
    output logic [CPU_EXE_MODE-1:0]  exe_mode_o,
    input  logic [IRQ_WIDTH-1:0]     irq_i,
    output logic                     if_stall_o,
    output logic                     id_stall_o,
    output logic                     ex_stall_o,
    output logic                     mem_stall_o,
    output logic                     if_flush_o,
    output logic                     id_flush_o,
    output logic                     ex_flush_o,
    output logic                     mem_flush_o,
    output logic [DE_ADD_WIDTH-1:0]  new_pc_o,
    output logic                     redirect_o
);

    logic                    stall_s;
    logic                    commit_ok_s;
    logic                    exc_s;
    logic                    exrt_s;
    logic                    wrcr_s;
    logic                    irq_take_s;
    logic [ISA_EXP_BUS-1:0]  exc_code_s;
    logic [ISA_EXP_BUS:0]    exc_word_s;
    logic [DE_ADD_WIDTH-1:0] exc_epc_s;
    logic [1:0]              status_s;
    logic [DE_DAT_WIDTH-1:0] vector_s;
    logic [DE_ADD_WIDTH-1:0] epc_s;
    logic [IRQ_WIDTH-1:0]    irq_mask_s;

    // Branch-shadow pipe: br_ex_q tracks the EX stage, delay_q the MEM stage.
    logic                    br_ex_q, br_ex_d;
    logic                    delay_q, delay_d;

    assign stall_s = if_busy_i | mem_busy_i;
    // rst_n is folded in so that asserting reset cancels a pending commit
    // combinationally, before any edge.
    assign commit_ok_s = rst_n & mem_en_i & ~stall_s;

`ifdef PCTRL_IRQ_EN
    logic [IRQ_WIDTH-1:0] irq_meta_q, irq_sync_q;

    // Interrupt is only taken on an instruction that commits nothing itself.
    assign irq_take_s = commit_ok_s
                      & (mem_exp_code_i == {ISA_EXP_BUS{1'b0}})
                      & (mem_ctrl_op_i != CTRL_WRCR)
                      & (mem_ctrl_op_i != CTRL_EXRT)
                      & status_s[STATUS_IE_BIT]
                      & (|(irq_sync_q & ~irq_mask_s));

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta_q <= {IRQ_WIDTH{1'b0}};
            irq_sync_q <= {IRQ_WIDTH{1'b0}};
        end else begin
            irq_meta_q <= irq_i;
            irq_sync_q <= irq_meta_q;
        end
    end
`else
    logic irq_unused_s;
    assign irq_unused_s = ^{irq_i, irq_mask_s};
    assign irq_take_s   = 1'b0;
`endif

    // Commit priority: exception > EXRT > WRCR.
    always_comb begin
        exc_s  = (commit_ok_s & (mem_exp_code_i != {ISA_EXP_BUS{1'b0}})) | irq_take_s;
        exrt_s = commit_ok_s & ~exc_s & (mem_ctrl_op_i == CTRL_EXRT);
        wrcr_s = commit_ok_s & ~exc_s & ~exrt_s & (mem_ctrl_op_i == CTRL_WRCR);
        if (irq_take_s) begin
            exc_code_s = ISA_EXP_BUS'(EXP_EXT_INT);
            exc_epc_s  = mem_pc_i;
        end else if (delay_q) begin
            // Faulting instruction sits in a delay slot: restart at the branch.
            exc_code_s = mem_exp_code_i;
            exc_epc_s  = mem_pc_i - DE_ADD_WIDTH'(1);
        end else begin
            exc_code_s = mem_exp_code_i;
            exc_epc_s  = mem_pc_i;
        end
        exc_word_s = {delay_q, exc_code_s};
    end

    // Stall, flush and redirect generation.
    always_comb begin
        if_stall_o  = rst_n & (stall_s | ld_hazard_i);
        id_stall_o  = rst_n & stall_s;
        ex_stall_o  = rst_n & stall_s;
        mem_stall_o = rst_n & stall_s;
        if_flush_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        mem_flush_o = 1'b0;
        redirect_o  = 1'b0;
        new_pc_o    = {DE_ADD_WIDTH{1'b0}};
        if (exc_s || exrt_s) begin
            if_flush_o  = 1'b1;
            id_flush_o  = 1'b1;
            ex_flush_o  = 1'b1;
            mem_flush_o = 1'b1;
            redirect_o  = 1'b1;
            new_pc_o    = exc_s ? vector_s[DE_DAT_WIDTH-1:2] : epc_s;
        end else if (wrcr_s) begin
            // Restart just after the WRCR so younger instructions see its effect.
            if_flush_o = 1'b1;
            id_flush_o = 1'b1;
            ex_flush_o = 1'b1;
            redirect_o = 1'b1;
            new_pc_o   = mem_pc_i + DE_ADD_WIDTH'(1);
        end else if (rst_n && !stall_s && ld_hazard_i) begin
            // Bubble into EX while ID/IF hold the dependent instruction.
            id_flush_o = 1'b1;
        end else begin
            redirect_o = 1'b0;
        end
    end

    // Next state of the branch-shadow pipe, following the stage registers.
    always_comb begin
        br_ex_d = br_ex_q;
        delay_d = delay_q;
        if (stall_s) begin
            br_ex_d = br_ex_q;
            delay_d = delay_q;
        end else if (exc_s || exrt_s || wrcr_s) begin
            br_ex_d = 1'b0;
            delay_d = 1'b0;
        end else if (ld_hazard_i) begin
            br_ex_d = 1'b0;
            delay_d = br_ex_q;
        end else begin
            br_ex_d = id_br_flag_i;
            delay_d = br_ex_q;
        end
    end

    // Branch-shadow pipe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_ex_q <= 1'b0;
            delay_q <= 1'b0;
        end else begin
            br_ex_q <= br_ex_d;
            delay_q <= delay_d;
        end
    end

    creg_file #(
        .DE_ADD_WIDTH  (DE_ADD_WIDTH),
        .DE_DAT_WIDTH  (DE_DAT_WIDTH),
        .REG_ADD_WIDTH (REG_ADD_WIDTH),
        .ISA_EXP_BUS   (ISA_EXP_BUS),
        .IRQ_WIDTH     (IRQ_WIDTH)
    ) u_creg (
        .clk           (clk),
        .rst_n         (rst_n),
        .exc_commit_i  (exc_s),
        .exc_code_i    (exc_word_s),
        .exc_epc_i     (exc_epc_s),
        .exrt_commit_i (exrt_s),
        .wr_en_i       (wrcr_s),
        .wr_addr_i     (mem_dst_addr_i),
        .wr_data_i     (mem_wr_data_i),
        .rd_addr_i     (creg_rd_addr_i),
        .rd_data_o     (creg_rd_data_o),
        .status_o      (status_s),
        .vector_o      (vector_s),
        .epc_o         (epc_s),
        .irq_mask_o    (irq_mask_s)
    );

    assign exe_mode_o = CPU_EXE_MODE'(status_s[STATUS_MODE_BIT]);

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// A table of combinational vectors covers stall/flush/redirect decoding;
// hand-written sequences cover commits, delay slots, wrap, reset abort and
// (with PCTRL_IRQ_EN) the interrupt path.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_busy_i, mem_busy_i, ld_hazard_i, id_br_flag_i, mem_en_i;
    logic [29:0] mem_pc_i;
    logic [1:0]  mem_ctrl_op_i;
    logic [2:0]  mem_exp_code_i;
    logic [4:0]  mem_dst_addr_i;
    logic [31:0] mem_wr_data_i;
    logic [4:0]  creg_rd_addr_i;
    logic [31:0] creg_rd_data_o;
    logic [0:0]  exe_mode_o;
    logic [7:0]  irq_i;
    logic        if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
    logic        if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
    logic [29:0] new_pc_o;
    logic        redirect_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_busy_i(if_busy_i), .mem_busy_i(mem_busy_i), .ld_hazard_i(ld_hazard_i),
        .id_br_flag_i(id_br_flag_i), .mem_en_i(mem_en_i), .mem_pc_i(mem_pc_i),
        .mem_ctrl_op_i(mem_ctrl_op_i), .mem_exp_code_i(mem_exp_code_i),
        .mem_dst_addr_i(mem_dst_addr_i), .mem_wr_data_i(mem_wr_data_i),
        .creg_rd_addr_i(creg_rd_addr_i), .creg_rd_data_o(creg_rd_data_o),
        .exe_mode_o(exe_mode_o), .irq_i(irq_i),
        .if_stall_o(if_stall_o), .id_stall_o(id_stall_o),
        .ex_stall_o(ex_stall_o), .mem_stall_o(mem_stall_o),
        .if_flush_o(if_flush_o), .id_flush_o(id_flush_o),
        .ex_flush_o(ex_flush_o), .mem_flush_o(mem_flush_o),
        .new_pc_o(new_pc_o), .redirect_o(redirect_o)
    );

    wire [3:0] stall_v = {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o};
    wire [3:0] flush_v = {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o};

    typedef struct {
        logic        ib, mb, lh, en;
        logic [1:0]  op;
        logic [2:0]  ex;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        rd;
        logic [29:0] np;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic ib, logic mb, logic lh, logic en, logic [1:0] op,
                                logic [2:0] ex, logic [3:0] st, logic [3:0] fl,
                                logic rd, logic [29:0] np);
        vec_t v;
        v.ib = ib; v.mb = mb; v.lh = lh; v.en = en; v.op = op; v.ex = ex;
        v.st = st; v.fl = fl; v.rd = rd; v.np = np;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string nm, input logic [4:0] a, input logic [31:0] exp);
        creg_rd_addr_i = a;
        #1;
        chk(nm, creg_rd_data_o, exp);
    endtask

    task automatic drive(input logic en, input logic [1:0] op, input logic [2:0] ex,
                         input logic [29:0] pc, input logic [4:0] dst, input logic [31:0] d);
        mem_en_i = en; mem_ctrl_op_i = op; mem_exp_code_i = ex;
        mem_pc_i = pc; mem_dst_addr_i = dst; mem_wr_data_i = d;
    endtask

    // WRCR that commits at the next edge, then idles the MEM stage.
    task automatic wrcr(input logic [4:0] a, input logic [31:0] d, input logic [29:0] pc);
        drive(1'b1, 2'd1, 3'd0, pc, a, d);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_busy_i = 1'b0; mem_busy_i = 1'b0; ld_hazard_i = 1'b0; id_br_flag_i = 1'b0;
        irq_i = 8'h00; creg_rd_addr_i = 5'd0;
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);

        // Vectors use mem_pc=0x40 with VECTOR=0x400 and EPC word=0x20 loaded.
        tbl[0]  = mk(0, 0, 0, 0, 2'd0, 3'd0, 4'h0, 4'h0, 0, 30'h0);
        tbl[1]  = mk(1, 0, 0, 0, 2'd0, 3'd0, 4'hF, 4'h0, 0, 30'h0);
        tbl[2]  = mk(0, 1, 0, 0, 2'd0, 3'd0, 4'hF, 4'h0, 0, 30'h0);
        tbl[3]  = mk(0, 0, 1, 0, 2'd0, 3'd0, 4'h8, 4'h4, 0, 30'h0);
        tbl[4]  = mk(1, 0, 1, 0, 2'd0, 3'd0, 4'hF, 4'h0, 0, 30'h0);
        tbl[5]  = mk(0, 0, 0, 1, 2'd0, 3'd3, 4'h0, 4'hF, 1, 30'h100);
        tbl[6]  = mk(0, 1, 0, 1, 2'd0, 3'd3, 4'hF, 4'h0, 0, 30'h0);
        tbl[7]  = mk(0, 0, 0, 1, 2'd2, 3'd0, 4'h0, 4'hF, 1, 30'h20);
        tbl[8]  = mk(0, 0, 0, 1, 2'd1, 3'd0, 4'h0, 4'hE, 1, 30'h41);
        tbl[9]  = mk(0, 0, 0, 1, 2'd1, 3'd4, 4'h0, 4'hF, 1, 30'h100);
        tbl[10] = mk(0, 0, 0, 1, 2'd2, 3'd6, 4'h0, 4'hF, 1, 30'h100);
        tbl[11] = mk(0, 0, 0, 0, 2'd1, 3'd5, 4'h0, 4'h0, 0, 30'h0);
        tbl[12] = mk(0, 0, 1, 1, 2'd1, 3'd0, 4'h8, 4'hE, 1, 30'h41);
        tbl[13] = mk(0, 0, 0, 1, 2'd3, 3'd0, 4'h0, 4'h0, 0, 30'h0);

        // Reset state.
        #2;
        chk("rst_stall", {28'd0, stall_v}, 32'h0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'h0);
        chk("rst_new_pc", {2'd0, new_pc_o}, 32'h0);
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_flush", {28'd0, flush_v}, 32'h0);
        chk("rel_redirect", {31'd0, redirect_o}, 32'h0);
        chk("rel_mode", {31'd0, exe_mode_o}, 32'h0);
        chk_reg("rel_status", 5'd0, 32'h0);
        chk_reg("rel_vector", 5'd3, 32'h0);
        chk_reg("rel_epc", 5'd4, 32'h0);

        // TRAP held under IF busy, then committed.
        if_busy_i = 1'b1;
        drive(1'b1, 2'd0, 3'd5, 30'h10, 5'd0, 32'd0);
        #1;
        chk("busy_stall", {28'd0, stall_v}, 32'hF);
        chk("busy_flush", {28'd0, flush_v}, 32'h0);
        chk("busy_redirect", {31'd0, redirect_o}, 32'h0);
        step();
        chk_reg("busy_no_update", 5'd2, 32'h0);
        if_busy_i = 1'b0;
        #1;
        chk("trap_flush", {28'd0, flush_v}, 32'hF);
        chk("trap_redirect", {31'd0, redirect_o}, 32'h1);
        chk("trap_new_pc", {2'd0, new_pc_o}, 32'h0);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("trap_exp_code", 5'd2, 32'h5);
        chk_reg("trap_epc", 5'd4, 32'h40);

        // WRCR VECTOR at the top of the PC space: redirect wraps to 0.
        drive(1'b1, 2'd1, 3'd0, 30'h3FFF_FFFF, 5'd3, 32'h0000_0400);
        creg_rd_addr_i = 5'd3;
        #1;
        chk("wrcr_redirect", {31'd0, redirect_o}, 32'h1);
        chk("wrcr_wrap_pc", {2'd0, new_pc_o}, 32'h0);
        chk("wrcr_flush", {28'd0, flush_v}, 32'hE);
        chk("wrcr_bypass", creg_rd_data_o, 32'h0000_0400);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("vector_rd", 5'd3, 32'h0000_0400);
        drive(1'b1, 2'd0, 3'd2, 30'h20, 5'd0, 32'd0);
        #1;
        chk("undef_new_pc", {2'd0, new_pc_o}, 32'h100);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("undef_exp_code", 5'd2, 32'h2);
        chk_reg("undef_epc", 5'd4, 32'h80);

        // Combinational decode table (mem_en dropped before any edge).
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if_busy_i = tbl[i].ib; mem_busy_i = tbl[i].mb; ld_hazard_i = tbl[i].lh;
            drive(tbl[i].en, tbl[i].op, tbl[i].ex, 30'h40, 5'd6, 32'h0);
            #1;
            chk($sformatf("tbl%0d_stall", i), {28'd0, stall_v}, {28'd0, tbl[i].st});
            chk($sformatf("tbl%0d_flush", i), {28'd0, flush_v}, {28'd0, tbl[i].fl});
            chk($sformatf("tbl%0d_redir", i), {31'd0, redirect_o}, {31'd0, tbl[i].rd});
            chk($sformatf("tbl%0d_new_pc", i), {2'd0, new_pc_o}, {2'd0, tbl[i].np});
            if_busy_i = 1'b0; mem_busy_i = 1'b0; ld_hazard_i = 1'b0;
            drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        end
        step();

        // User-mode TRAP in a delay slot, then EXRT back to user.
        wrcr(5'd0, 32'h1, 30'h30);
        chk("user_mode", {31'd0, exe_mode_o}, 32'h1);
        id_br_flag_i = 1'b1;
        step();
        id_br_flag_i = 1'b0;
        step();
        drive(1'b1, 2'd0, 3'd5, 30'h50, 5'd0, 32'd0);
        #1;
        chk("dly_redirect", {31'd0, redirect_o}, 32'h1);
        chk("dly_new_pc", {2'd0, new_pc_o}, 32'h100);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("dly_exp_code", 5'd2, 32'hD);
        chk_reg("dly_epc", 5'd4, 32'h13C);
        chk_reg("dly_status", 5'd0, 32'h0);
        chk_reg("dly_pre_status", 5'd1, 32'h1);
        chk("dly_mode", {31'd0, exe_mode_o}, 32'h0);
        drive(1'b1, 2'd2, 3'd0, 30'h60, 5'd0, 32'd0);
        #1;
        chk("exrt_redirect", {31'd0, redirect_o}, 32'h1);
        chk("exrt_new_pc", {2'd0, new_pc_o}, 32'h4F);
        chk("exrt_flush", {28'd0, flush_v}, 32'hF);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("exrt_status", 5'd0, 32'h1);
        chk("exrt_mode", {31'd0, exe_mode_o}, 32'h1);

        // WRCR blocked by MEM busy, and WRCR to an unimplemented address.
        mem_busy_i = 1'b1;
        drive(1'b1, 2'd1, 3'd0, 30'h64, 5'd3, 32'h800);
        #1;
        chk("mbusy_redirect", {31'd0, redirect_o}, 32'h0);
        step();
        mem_busy_i = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        chk_reg("mbusy_vector", 5'd3, 32'h400);
        wrcr(5'd6, 32'hFFFF, 30'h68);
        chk_reg("unimpl_rd", 5'd6, 32'h0);

`ifdef PCTRL_IRQ_EN
        wrcr(5'd5, 32'hFE, 30'h6A);
        wrcr(5'd0, 32'h2, 30'h6C);
        chk_reg("irq_mask_rd", 5'd5, 32'hFE);
        irq_i = 8'h02;
        drive(1'b1, 2'd0, 3'd0, 30'h70, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("irq_masked%0d", i), {31'd0, redirect_o}, 32'h0);
        end
        irq_i = 8'h01;
        step();
        chk("irq_sync1", {31'd0, redirect_o}, 32'h0);
        step();
        chk("irq_sync2", {31'd0, redirect_o}, 32'h1);
        chk("irq_new_pc", {2'd0, new_pc_o}, 32'h100);
        step();
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        irq_i = 8'h00;
        chk_reg("irq_exp_code", 5'd2, 32'h1);
        chk_reg("irq_epc", 5'd4, 32'h1C0);
        chk_reg("irq_status", 5'd0, 32'h0);
        chk_reg("irq_pre_status", 5'd1, 32'h2);
`else
        wrcr(5'd5, 32'hFE, 30'h6A);
        chk_reg("irq_mask_absent", 5'd5, 32'h0);
        wrcr(5'd0, 32'h2, 30'h6C);
        irq_i = 8'hFF;
        drive(1'b1, 2'd0, 3'd0, 30'h70, 5'd0, 32'd0);
        step(); step(); step();
        chk("irq_ignored", {31'd0, redirect_o}, 32'h0);
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        irq_i = 8'h00;
`endif

        // Reset in the middle of a WRCR commit aborts it at once.
        drive(1'b1, 2'd1, 3'd0, 30'h90, 5'd3, 32'hABC);
        #1;
        chk("pre_rst_redirect", {31'd0, redirect_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_redirect", {31'd0, redirect_o}, 32'h0);
        chk("mid_rst_flush", {28'd0, flush_v}, 32'h0);
        step();
        @(negedge clk);
        drive(1'b0, 2'd0, 3'd0, 30'd0, 5'd0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk_reg("post_rst_vector", 5'd3, 32'h0);
        chk_reg("post_rst_status", 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Generates per-stage stall and flush, and drives the PC redirect.
- Owns the control-register file (mode, exception state, EPC, vector base) that the decoder reads through creg_rd_addr/creg_rd_data.
- Commits exceptions, WRCR and EXRT at the MEM stage boundary. This makes them precise.

Parameters:
- DE_ADD_WIDTH, 30, word-address width of the PC.
- DE_DAT_WIDTH, 32, data and control-register width.
- REG_ADD_WIDTH, 5, control-register address width.
- CTRL_OP_BUS, 2, width of ctrl_op.
- ISA_EXP_BUS, 3, width of the exception code.
- CPU_EXE_MODE, 1, width of the execution mode.
- IRQ_WIDTH, 8, external interrupt lines (optional feature only).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_busy_i  in  1  IF bus access not complete.
- mem_busy_i  in  1  MEM bus access not complete.
- ld_hazard_i  in  1  load-use hazard from the decoder.
- id_br_flag_i  in  1  branch instruction in ID, used for delay-slot tracking in EPC.
- mem_en_i  in  1  MEM stage holds a valid instruction.
- mem_pc_i  in  DE_ADD_WIDTH  PC of the MEM-stage instruction.
- mem_ctrl_op_i  in  CTRL_OP_BUS  0=NOP, 1=WRCR, 2=EXRT.
- mem_exp_code_i  in  ISA_EXP_BUS  0=NONE, 1=EXT_INT, 2=UNDEF, 3=OVF, 4=MISALIGN, 5=TRAP, 6=PRV_VIO.
- mem_dst_addr_i  in  REG_ADD_WIDTH  control-register address for WRCR.
- mem_wr_data_i  in  DE_DAT_WIDTH  WRCR data.
- creg_rd_addr_i  in  REG_ADD_WIDTH  decoder read address.
- creg_rd_data_o  out  DE_DAT_WIDTH  combinational read data.
- exe_mode_o  out  CPU_EXE_MODE  0=KERNEL, 1=USER.
- irq_i  in  IRQ_WIDTH  level interrupts (optional feature only).
- if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold the stage register.
- if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  invalidate the stage register.
- new_pc_o  out  DE_ADD_WIDTH  redirect target.
- redirect_o  out  1  IF loads new_pc_o this cycle.

Behaviour:
- Stalls (combinational):
  - stall = if_busy_i | mem_busy_i.
  - if_stall = stall | ld_hazard_i.
  - id_stall = ex_stall = mem_stall = stall.
  - On ld_hazard_i without stall: id_flush=1, inserting one bubble into EX.
- Commit event: valid only when mem_en_i=1 and stall=0. Priority order:
  1. exception (mem_exp_code_i != 0),
  2. EXRT,
  3. WRCR.
- While stall=1 there is no commit, no flush, redirect_o=0, and no register update.
- Exception commit:
  - Combinationally: all four flushes = 1, redirect_o=1, new_pc_o = VECTOR[31:2].
  - At the clock edge: PRE_STATUS <= STATUS; STATUS.mode <= KERNEL; STATUS.ie <= 0; EXP_CODE <= {delay_flag, code}; EPC <= mem_pc_i, or mem_pc_i-1 if delay_flag.
  - delay_flag is a register set when the instruction entering MEM followed a branch (id_br_flag pipelined two stages internally).
- EXRT commit: flushes all, redirect to EPC; STATUS <= PRE_STATUS at the edge.
- EXRT in user mode cannot arrive. The decoder converts it to PRV_VIO, which takes precedence.
- WRCR commit: write mem_wr_data_i to creg[mem_dst_addr_i]; flush IF/ID/EX; redirect to mem_pc_i+1 with wrap modulo 2^DE_ADD_WIDTH. This lets younger instructions observe the new mode.
- Control registers:
  - 0 STATUS {ie[1], mode[0]}
  - 1 PRE_STATUS
  - 2 EXP_CODE {dly[3], code[2:0]}
  - 3 VECTOR
  - 4 EPC {pc, 2'b00}
  - 5 IRQ_MASK (optional feature)
  - Other addresses: read 0, writes ignored.
- Read bypass: a WRCR committing this cycle to the same address returns mem_wr_data_i on creg_rd_data_o.
- Reset values:
  - STATUS mode=KERNEL, ie=0. All other registers 0.
  - All stalls, flushes and redirect_o = 0. new_pc_o = 0. delay pipe cleared.
- Reset asserted mid-operation aborts the pending commit immediately. No register update occurs.

Optional Feature:
- PCTRL_IRQ_EN defined:
  - IRQ_MASK register (5) is implemented; irq_i is sampled through a 2-flop synchroniser.
  - When STATUS.ie=1 and |(irq_sync & ~IRQ_MASK), an EXT_INT exception is taken at the next commit-free non-stalled cycle with mem_en_i=1, replacing that instruction.
  - EPC is set to that instruction's PC.
- PCTRL_IRQ_EN undefined: irq_i is ignored, register 5 reads 0, and no EXT_INT is generated internally.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - ctrl_op_e
  - exp_code_e
  - exe_mode_e
  - creg address constants CREG_STATUS..CREG_IRQ_MASK
  - the STATUS bit positions
- Sub-module creg_file: control-register storage, read mux and bypass.
- Commit and priority logic stay in pipe_ctrl.

Test Plan:
- Reset release → STATUS=0x0 (kernel, ie=0), all flushes 0, redirect_o=0, creg_rd_data for addr 0 = 0.
- if_busy_i=1 with mem_exp_code_i=5 and mem_en_i=1 → all stalls=1, no redirect. Drop busy → flush all, new_pc=VECTOR>>2, EXP_CODE=5.
- WRCR addr 3 = 0x0000_0400 at mem_pc=0x3FFF_FFFF → redirect to 0x0000_0000 (wrap); next exception → new_pc=0x100.
- ld_hazard_i=1 alone → if_stall=1, id_flush=1, other stalls/flushes 0.
- TRAP in user mode with the instruction behind a branch → EXP_CODE=0xD, EPC=(pc-1)<<2, STATUS.mode=0. Then EXRT → STATUS restored to user, redirect to EPC.
- With PCTRL_IRQ_EN: ie=1, IRQ_MASK=0xFE, irq_i=0x01 → EXT_INT after 2-cycle sync. With irq_i=0x02 → no interrupt.
